elastic_stage_register: RTL and testbench

- Parametrised successor to the fixed-width, always-load inter-stage registers.
- Generic ready/valid pipeline stage of WIDTH bits with optional two-entry skid buffer, synchronous flush and a saturating flush-discard counter.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) so hazard stalls propagate as back-pressure instead of global freezes.
- Callers pack their fields into in_data, MSB first, in pipeline order.

---
 rtl/elastic_stage_register.sv | 100 ++++++++++
 tb/tb_elastic_stage_register.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/elastic_stage_register.sv
// Ready/valid pipeline stage with an optional two-entry skid buffer, synchronous
// flush and a saturating count of beats destroyed by flush.
module elastic_stage_register #(
   parameter int unsigned       WIDTH       = 150,
   parameter int unsigned       SKID        = 1,
   parameter logic [WIDTH-1:0]  FLUSH_VALUE = '0,
   parameter int unsigned       CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] flush_count
);

   logic             r_m_valid, w_m_valid_d;
   logic [WIDTH-1:0] r_m_data,  w_m_data_d;
   logic             r_s_valid, w_s_valid_d;
   logic [WIDTH-1:0] r_s_data,  w_s_data_d;
   logic [CNT_W-1:0] r_flush_count, w_flush_count_d;

   logic             w_push;
   logic             w_pop;
   logic [1:0]       w_flush_inc;
   logic [CNT_W+1:0] w_cnt_sum;
   logic [CNT_W-1:0] w_cnt_sat;

   // With the skid entry, in_ready depends only on flops (and rst), never on out_ready.
   assign in_ready = (SKID != 0) ? (~r_s_valid & ~rst)
                                 : (~rst & (~r_m_valid | out_ready));

   assign w_push = in_valid & in_ready;
   assign w_pop  = r_m_valid & out_ready;

   assign out_valid   = r_m_valid;
   assign out_data    = r_m_data;
   assign occupancy   = {1'b0, r_m_valid} + {1'b0, r_s_valid};
   assign flush_count = r_flush_count;

   // A head beat popped in the flush cycle was delivered, so it is not counted.
   assign w_flush_inc = {1'b0, r_m_valid & ~out_ready} + {1'b0, r_s_valid} + {1'b0, w_push};
   assign w_cnt_sum   = {2'b00, r_flush_count} + (CNT_W+2)'(w_flush_inc);
   assign w_cnt_sat   = (|w_cnt_sum[CNT_W+1:CNT_W]) ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

   always_comb begin
      w_m_valid_d     = r_m_valid;
      w_m_data_d      = r_m_data;
      w_s_valid_d     = r_s_valid;
      w_s_data_d      = r_s_data;
      w_flush_count_d = r_flush_count;

      if (flush) begin
         w_m_valid_d     = 1'b0;
         w_m_data_d      = FLUSH_VALUE;
         w_s_valid_d     = 1'b0;
         w_s_data_d      = FLUSH_VALUE;
         w_flush_count_d = w_cnt_sat;
      end else if (w_pop) begin
         if (r_s_valid) begin
            w_m_data_d  = r_s_data;
            w_s_valid_d = 1'b0;
         end else if (w_push) begin
            w_m_data_d = in_data;
         end else begin
            w_m_valid_d = 1'b0;
         end
      end else if (w_push) begin
         if (!r_m_valid) begin
            w_m_valid_d = 1'b1;
            w_m_data_d  = in_data;
         end else if (SKID != 0) begin
            w_s_valid_d = 1'b1;
            w_s_data_d  = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_valid     <= 1'b0;
         r_m_data      <= FLUSH_VALUE;
         r_s_valid     <= 1'b0;
         r_s_data      <= FLUSH_VALUE;
         r_flush_count <= '0;
      end else begin
         r_m_valid     <= w_m_valid_d;
         r_m_data      <= w_m_data_d;
         r_s_valid     <= w_s_valid_d;
         r_s_data      <= w_s_data_d;
         r_flush_count <= w_flush_count_d;
      end
   end

endmodule

// File: tb/tb_elastic_stage_register.sv
// Drives three stage variants (skid, no-skid, 2-bit counter) with shared stimulus and
// compares each against a queue-based reference model.
module tb_elastic_stage_register;

   localparam logic [15:0] FV = 16'hA5A5;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [15:0] in_data;

   logic        rdy [3];
   logic        ov  [3];
   logic [15:0] od  [3];
   logic [1:0]  occ [3];
   logic [15:0] cnt0, cnt1;
   logic [1:0]  cnt2;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a plain FIFO per instance plus the last visible head value.
   logic [15:0] mq [3][$];
   logic [15:0] m_held [3];
   int unsigned m_cnt [3];
   int unsigned m_skid [3]    = '{1, 0, 1};
   int unsigned m_cnt_max [3] = '{65535, 65535, 3};

   always #5 clk = ~clk;

   elastic_stage_register #(.WIDTH(16), .SKID(1), .FLUSH_VALUE(FV), .CNT_W(16)) u_dut_skid (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
      .occupancy(occ[0]), .flush_count(cnt0));

   elastic_stage_register #(.WIDTH(16), .SKID(0), .FLUSH_VALUE(FV), .CNT_W(16)) u_dut_noskid (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
      .occupancy(occ[1]), .flush_count(cnt1));

   elastic_stage_register #(.WIDTH(16), .SKID(1), .FLUSH_VALUE(FV), .CNT_W(2)) u_dut_sat (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
      .occupancy(occ[2]), .flush_count(cnt2));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] act_cnt(input int k);
      if (k == 0) return {16'h0, cnt0};
      if (k == 1) return {16'h0, cnt1};
      return {30'h0, cnt2};
   endfunction

   function automatic logic [15:0] model_head(input int k);
      return (mq[k].size() > 0) ? mq[k][0] : m_held[k];
   endfunction

   task automatic step(input logic r, input logic f, input logic v, input logic [15:0] d,
                       input logic ordy);
      logic exp_rdy [3];
      int   disc;
      logic push, pop;
      @(negedge clk);
      rst = r; flush = f; in_valid = v; in_data = d; out_ready = ordy;
      #1;
      for (int k = 0; k < 3; k++) begin
         if (m_skid[k] != 0) exp_rdy[k] = !r && (mq[k].size() < 2);
         else                exp_rdy[k] = !r && ((mq[k].size() == 0) || ordy);
         check($sformatf("in_ready[%0d]", k),    {31'h0, rdy[k]}, {31'h0, exp_rdy[k]});
         check($sformatf("out_valid[%0d]", k),   {31'h0, ov[k]},  {31'h0, mq[k].size() > 0});
         check($sformatf("out_data[%0d]", k),    {16'h0, od[k]},  {16'h0, model_head(k)});
         check($sformatf("occupancy[%0d]", k),   {30'h0, occ[k]}, 32'(mq[k].size()));
         check($sformatf("flush_count[%0d]", k), act_cnt(k),      m_cnt[k]);
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         push = v && exp_rdy[k];
         pop  = (mq[k].size() > 0) && ordy;
         if (r) begin
            mq[k].delete();
            m_held[k] = FV;
            m_cnt[k]  = 0;
         end else if (f) begin
            disc     = mq[k].size() - int'(pop) + int'(push);
            m_cnt[k] = (m_cnt[k] + disc > m_cnt_max[k]) ? m_cnt_max[k] : m_cnt[k] + disc;
            mq[k].delete();
            m_held[k] = FV;
         end else begin
            if (pop)  void'(mq[k].pop_front());
            if (push) mq[k].push_back(d);
            if (mq[k].size() > 0) m_held[k] = mq[k][0];
         end
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         mq[k].delete();
         m_held[k] = FV;
         m_cnt[k]  = 0;
      end
      step(1, 0, 0, 16'h0, 0);
      step(0, 0, 0, 16'h0, 0);

      // Streaming at full rate
      for (int i = 1; i <= 5; i++) begin
         step(0, 0, 1, 16'(i), 1);
         #1 check("stream_data", {16'h0, od[0]}, 32'(i));
      end
      step(0, 0, 0, 16'h0, 1);

      // Back-pressure fills the skid entry
      step(0, 0, 1, 16'h000A, 0);
      step(0, 0, 1, 16'h000B, 0);
      #1;
      check("bp_occ",   {30'h0, occ[0]}, 32'd2);
      check("bp_data",  {16'h0, od[0]},  32'h0A);
      check("bp_ready", {31'h0, rdy[0]}, 32'd0);
      step(0, 0, 0, 16'h0, 0);
      step(0, 0, 0, 16'h0, 1);
      #1;
      check("bp_second", {16'h0, od[0]},  32'h0B);
      check("bp_ready1", {31'h0, rdy[0]}, 32'd1);
      step(0, 0, 0, 16'h0, 1);

      // Flush while full with downstream stalled: head and skid beats are lost
      step(0, 0, 1, 16'h000A, 0);
      step(0, 0, 1, 16'h000B, 0);
      step(0, 1, 1, 16'h000C, 0);
      #1;
      check("fl_valid", {31'h0, ov[0]},  32'd0);
      check("fl_data",  {16'h0, od[0]},  {16'h0, FV});
      check("fl_occ",   {30'h0, occ[0]}, 32'd0);
      check("fl_cnt",   {16'h0, cnt0},   32'd2);
      // Same with downstream ready: the head beat counts as delivered
      step(0, 0, 1, 16'h0021, 0);
      step(0, 0, 1, 16'h0022, 0);
      step(0, 1, 1, 16'h0023, 1);
      #1 check("fl_cnt2", {16'h0, cnt0}, 32'd3);
      step(0, 0, 1, 16'h0031, 0);
      step(0, 0, 1, 16'h0032, 0);
      step(0, 1, 0, 16'h0, 0);
      #1;
      check("fl_cnt3", {16'h0, cnt0}, 32'd5);
      check("sat_cnt", {30'h0, cnt2}, 32'd3);

      // No-skid replacement of the head in the same edge
      step(0, 0, 1, 16'h0011, 0);
      step(0, 0, 1, 16'h0022, 1);
      #1;
      check("ns_occ",  {30'h0, occ[1]}, 32'd1);
      check("ns_data", {16'h0, od[1]},  32'h22);

      // Reset together with flush while full
      step(0, 0, 1, 16'h0041, 0);
      step(0, 0, 1, 16'h0042, 0);
      step(1, 1, 1, 16'h0043, 0);
      #1;
      check("rst_occ",   {30'h0, occ[0]}, 32'd0);
      check("rst_cnt",   {16'h0, cnt0},   32'd0);
      check("rst_ready", {31'h0, rdy[0]}, 32'd0);
      step(0, 0, 0, 16'h0, 0);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 149) == 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0);
      end
      step(0, 0, 0, 16'h0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
